mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values are even integers 4..64.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request strobe, sampled each rising edge.
REQ-005 Op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
REQ-006 A  input  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO source).
REQ-007 B  input  WIDTH  operand B (multiplier or divisor).
REQ-008 Busy  output  1  high while an iterative operation is in flight.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 HiOut  output  WIDTH  architectural HI register, continuously driven (serves MFHI).
REQ-011 LoOut  output  WIDTH  architectural LO register, continuously driven (serves MFLO).
REQ-012 DivByZero  output  1  divide-by-zero flag; valid only in the Done cycle, 0 otherwise.

Function
REQ-013 FSM states: IDLE, RUN, FINISH; the reset state is IDLE.
REQ-014 A request is accepted only when Start=1 in IDLE; Start in RUN or FINISH is ignored, with no queueing and no effect on the operation in flight.
REQ-015 Op, A and B are captured on the accepting edge; later input changes do not affect the result.
REQ-016 MTHI/MTLO: the accepting edge writes A into HI or LO; Done=1 the next cycle; Busy stays 0; the other register is unchanged.
REQ-017 MULT/MULTU/DIV/DIVU/MADD/MSUB: the accepting edge moves IDLE->RUN.
REQ-018 RUN lasts exactly WIDTH cycles and performs one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle, then moves to FINISH.
REQ-019 FINISH lasts one cycle: sign correction, accumulation, and write of HI/LO on its closing edge; the FSM then returns to IDLE.
REQ-020 Busy=1 in RUN and FINISH, i.e. WIDTH+1 cycles; Done=1 for exactly one cycle, the first IDLE cycle after FINISH, when the new HI/LO values are already visible.
REQ-021 A new Start is accepted in the Done cycle, giving back-to-back issue.
REQ-022 Signed operations use magnitude iteration on |A| and |B|, then negate the result per operand signs.
REQ-023 MULT/MULTU: {HI,LO} is the full 2*WIDTH-bit signed or unsigned product.
REQ-024 MADD/MSUB: {HI,LO} becomes {HI,LO} plus or minus the signed 2*WIDTH product, modulo 2^(2*WIDTH); HI/LO are read in FINISH.
REQ-025 DIV/DIVU: LO is the quotient and HI the remainder.
REQ-026 Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-027 Signed most-negative / -1 gives LO = most-negative value, HI = 0, DivByZero = 0.
REQ-028 B=0 on DIV/DIVU still takes the full latency, gives LO = all ones and HI = A, and sets DivByZero=1 in the Done cycle.
REQ-029 HI/LO change only per REQ-016, REQ-019 and Reset.

Reset
REQ-030 Reset=1 at an edge forces IDLE, Busy=0, Done=0, DivByZero=0, HiOut=0, LoOut=0, and clears the iteration counter and datapath registers.
REQ-031 Reset overrides Start on the same edge; the request is dropped.
REQ-032 Reset during RUN or FINISH aborts the operation; no Done pulse is produced for it.

Verification (WIDTH=32 unless stated)
REQ-033 MULT A=0xFFFFFFFD, B=7 -> Busy for 33 cycles, then Done with HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB.
REQ-034 MULTU A=B=0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001; then back-to-back DIV A=0xFFFFFFF9, B=2 issued in the Done cycle -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF.
REQ-035 DIVU A=7, B=0 -> DivByZero=1 in the Done cycle, LoOut=0xFFFFFFFF, HiOut=7. DIV A=0x80000000, B=0xFFFFFFFF -> LoOut=0x80000000, HiOut=0, DivByZero=0.
REQ-036 MTHI 5, then MTLO 10 (Done one cycle each, Busy never high), then MADD A=2, B=3 -> HiOut=5, LoOut=16; then MSUB A=2, B=3 -> HiOut=5, LoOut=10.
REQ-037 Start pulses with new Op/A/B during Busy leave the result unchanged; Reset asserted in RUN cycle 10 of a DIV -> next cycle Busy=0, HiOut=LoOut=0, and no Done for that DIV.
REQ-038 WIDTH=8, MULTU A=B=0xFF -> Busy for 9 cycles, then Done with HiOut=0xFE, LoOut=0x01.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per RUN cycle, then a FINISH cycle for sign fix-up and HI/LO write.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, a_mag_reg, b_mag_reg;
  logic               a_neg_reg, b_neg_reg, b_zero_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg, dbz_reg;

  // Operand decode on the raw inputs, used only on the accepting edge
  logic             op_signed_in, op_div_in, op_iter_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign op_signed_in = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign op_div_in    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_iter_in   = (op != OP_MTHI) && (op != OP_MTLO);
  assign a_neg_in     = op_signed_in & a[WIDTH-1];
  assign b_neg_in     = op_signed_in & b[WIDTH-1];
  assign a_mag_in     = a_neg_in ? -a : a;
  assign b_mag_in     = b_neg_in ? -b : b;

  // Per-cycle iteration steps: work_reg holds {acc, multiplier} or {remainder, dividend/quotient}
  logic             op_div_reg, div_ge;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign op_div_reg = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  assign mul_sum    = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, a_mag_reg} : '0);
  assign mul_next   = {mul_sum, work_reg[WIDTH-1:1]};
  assign div_shift  = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, b_mag_reg};
  assign div_diff   = div_shift - {1'b0, b_mag_reg};
  assign div_next   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       work_reg[WIDTH-2:0], div_ge};

  // FINISH-cycle result: sign correction and accumulation
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign res_neg     = a_neg_reg ^ b_neg_reg;
  assign prod_signed = res_neg ? -work_reg : work_reg;

  always_comb begin
    fin_hi = hi_reg;
    fin_lo = lo_reg;
    case (op_reg)
      OP_MULT, OP_MULTU: {fin_hi, fin_lo} = prod_signed;
      OP_MADD:           {fin_hi, fin_lo} = {hi_reg, lo_reg} + prod_signed;
      OP_MSUB:           {fin_hi, fin_lo} = {hi_reg, lo_reg} - prod_signed;
      OP_DIV, OP_DIVU: begin
        if (b_zero_reg) begin
          fin_lo = '1;
          fin_hi = a_reg;
        end else begin
          fin_lo = res_neg   ? -work_reg[WIDTH-1:0]       : work_reg[WIDTH-1:0];
          fin_hi = a_neg_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && op_iter_in) state_next = RUN;
      RUN:     if (count_reg == CW'(WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      work_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi_reg   <= a;
              done_reg <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_reg   <= a;
              done_reg <= 1'b1;
            end else begin
              op_reg     <= op;
              a_reg      <= a;
              a_mag_reg  <= a_mag_in;
              b_mag_reg  <= b_mag_in;
              a_neg_reg  <= a_neg_in;
              b_neg_reg  <= b_neg_in;
              b_zero_reg <= (b == '0);
              work_reg   <= {{WIDTH{1'b0}}, (op_div_in ? a_mag_in : b_mag_in)};
              count_reg  <= '0;
            end
          end
        end
        RUN: begin
          work_reg  <= op_div_reg ? div_next : mul_next;
          count_reg <= count_reg + 1'b1;
        end
        FINISH: begin
          hi_reg   <= fin_hi;
          lo_reg   <= fin_lo;
          done_reg <= 1'b1;
          dbz_reg  <= op_div_reg & b_zero_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign hi_out      = hi_reg;
  assign lo_out      = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table for single operations plus
// hand-written sequences for busy-time starts, resets and the 8-bit instance.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi_out(hi8), .lo_out(lo8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          nbusy;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a post-edge point; returns in the Done cycle (or after the bound)
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int nbusy, output logic dn, output logic dz);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7; a = 32'hDEAD_BEEF; b = 32'h0;
    nbusy = 0;
    while (busy && nbusy < 200) begin
      nbusy++;
      @(posedge clk); #1;
    end
    dn = done;
    dz = div_by_zero;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   nb;
    logic dn, dz, seen;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1, 33};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[5]  = '{3'd6, 32'd5,        32'd0,        32'h00000005, 32'h80000000, 1'b0, 0};
    vecs[6]  = '{3'd7, 32'd10,       32'd0,        32'h00000005, 32'h0000000A, 1'b0, 0};
    vecs[7]  = '{3'd4, 32'd2,        32'd3,        32'h00000005, 32'h00000010, 1'b0, 33};
    vecs[8]  = '{3'd5, 32'd2,        32'd3,        32'h00000005, 32'h0000000A, 1'b0, 33};
    vecs[9]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33};
    vecs[10] = '{3'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33};
    vecs[11] = '{3'd2, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
    vecs[12] = '{3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, 33};
    vecs[13] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
    vecs[14] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 33};
    vecs[15] = '{3'd4, 32'd1,        32'd1,        32'hFFFFFFFA, 32'h00000000, 1'b0, 33};
    vecs[16] = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFA, 32'h00000001, 1'b0, 33};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
    check("reset_hi",   {32'd0, hi_out}, 64'd0);
    check("reset_lo",   {32'd0, lo_out}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Consecutive entries are issued in the previous Done cycle (back-to-back)
    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, nb, dn, dz);
      $display("txn %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b busy_cycles=%0d done=%b",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi_out, lo_out, dz, nb, dn);
      check($sformatf("v%0d_busy", i), 64'(nb), 64'(vecs[i].nbusy));
      check($sformatf("v%0d_done", i), {63'd0, dn}, 64'd1);
      check($sformatf("v%0d_dbz", i),  {63'd0, dz}, {63'd0, vecs[i].dbz});
      check($sformatf("v%0d_hi", i),   {32'd0, hi_out}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i),   {32'd0, lo_out}, {32'd0, vecs[i].lo});
    end

    // Start pulses in RUN and in FINISH must be ignored
    op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      if (nb == 5 || nb == 33) begin
        start = 1'b1; op = 3'd6; a = 32'h1234; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("txn busy_start multu 3*5 -> hi=%h lo=%h busy_cycles=%0d done=%b", hi_out, lo_out, nb, done);
    check("ign_busy", 64'(nb), 64'd33);
    check("ign_done", {63'd0, done}, 64'd1);
    check("ign_hi",   {32'd0, hi_out}, 64'd0);
    check("ign_lo",   {32'd0, lo_out}, 64'd15);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("dbz_outside_done", {63'd0, div_by_zero}, 64'd0);
    check("no_queued_mthi", {32'd0, hi_out}, 64'd0);

    // Reset in RUN cycle 10 of a DIV aborts it without a Done
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort_in_run", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("txn abort div -> busy=%b hi=%h lo=%h", busy, hi_out, lo_out);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi_out}, 64'd0);
    check("abort_lo", {32'd0, lo_out}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", {63'd0, seen}, 64'd0);

    // Reset wins over a simultaneous Start
    issue(3'd6, 32'h55, 32'd0, nb, dn, dz);
    $display("txn mthi 55 -> hi=%h lo=%h done=%b", hi_out, lo_out, dn);
    check("mthi55_hi", {32'd0, hi_out}, 64'h55);
    op = 3'd7; a = 32'h77; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    $display("txn reset+mtlo -> hi=%h lo=%h done=%b", hi_out, lo_out, done);
    check("rst_start_hi", {32'd0, hi_out}, 64'd0);
    check("rst_start_lo", {32'd0, lo_out}, 64'd0);
    check("rst_start_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("rst_start_done", {63'd0, done}, 64'd0);

    // 8-bit instance
    op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    nb = 0;
    while (busy8 && nb < 100) begin
      nb++;
      @(posedge clk); #1;
    end
    $display("txn w8 multu ff*ff -> hi=%h lo=%h busy_cycles=%0d done=%b", hi8, lo8, nb, done8);
    check("w8_busy", 64'(nb), 64'd9);
    check("w8_done", {63'd0, done8}, 64'd1);
    check("w8_hi", {56'd0, hi8}, 64'hFE);
    check("w8_lo", {56'd0, lo8}, 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
